store_packer: RTL

Memory-stage store packer: the write-side counterpart of the load/immediate extenders. It takes a store request (sw/sh/sb, byte address, full register value), narrows and replicates the data into the correct byte lanes, generates byte enables, checks alignment, and queues the result in a 2-entry write buffer drained to data memory over a req/ack handshake. It sits between the MEM pipeline register and the data memory port.

---
 rtl/store_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/store_packer.sv
// Memory-stage store packer: lane-replicates sw/sh/sb data, builds byte enables and
// queues stores in a 2-entry write buffer drained over req/ack. Option: STORE_ALIGN_CHECK_EN.
module store_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [1:0]  pend_cnt
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_type_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  function automatic entry_t pack_store(input logic [1:0] t, input logic [31:0] a,
                                        input logic [31:0] d);
    entry_t e;
    e.addr = {a[31:2], 2'b00};
    case (st_type_e'(t))
      ST_SW: begin
        e.wdata = d;
        e.be    = 4'b1111;
      end
      ST_SH: begin
        e.wdata = {2{d[15:0]}};
        e.be    = a[1] ? 4'b1100 : 4'b0011;
      end
      ST_SB: begin
        e.wdata = {4{d[7:0]}};
        e.be    = 4'b0001 << a[1:0];
      end
      default: begin
        e.wdata = 32'h0000_0000;
        e.be    = 4'b0000;
      end
    endcase
    return e;
  endfunction

`ifdef STORE_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a_lo);
    logic bad;
    case (st_type_e'(t))
      ST_SW:   bad = (a_lo != 2'b00);
      ST_SH:   bad = a_lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  entry_t     fifo_r [2];
  entry_t     head_r;
  entry_t     entry_in_s;
  entry_t     head_next_s;
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       rd_next_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_next_s;
  logic       err_r;
  logic       type_ok_s;
  logic       bad_align_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;

  // Ready depends only on occupancy so a full buffer never accepts on the ack cycle.
  assign st_ready  = (cnt_r != FULL_CNT);
  assign mem_req   = (cnt_r != 2'd0);
  assign pend_cnt  = cnt_r;
  assign st_err    = err_r;
  assign mem_addr  = head_r.addr;
  assign mem_wdata = head_r.wdata;
  assign mem_be    = head_r.be;

  // Handshake decode, occupancy update and next head selection.
  always_comb begin
    entry_in_s = pack_store(st_type, st_addr, st_data);
    type_ok_s  = (st_type != 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
    bad_align_s = misaligned(st_type, st_addr[1:0]);
`else
    bad_align_s = 1'b0;
`endif
    accept_s  = st_valid && st_ready;
    push_s    = accept_s && type_ok_s && !bad_align_s;
    pop_s     = mem_req && mem_ack;
    rd_next_s = pop_s ? ~rd_ptr_r : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + 2'd1;
      2'b01:   cnt_next_s = cnt_r - 2'd1;
      default: cnt_next_s = cnt_r;
    endcase
    // An entry written this edge into the slot that becomes head bypasses storage.
    if (cnt_next_s == 2'd0) begin
      head_next_s = head_r;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = entry_in_s;
    end else begin
      head_next_s = fifo_r[rd_next_s];
    end
  end

  // Write-buffer storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_r[i] <= '0;
      end
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= entry_in_s;
    end
  end

  // Pointers, occupancy, registered head outputs and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      head_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r <= rd_next_s;
      cnt_r    <= cnt_next_s;
      head_r   <= head_next_s;
      err_r    <= accept_s && type_ok_s && bad_align_s;
    end
  end

endmodule
